// File: rtl/bcd_counter_chain_pkg.sv
// Shared constants and digit-indexing helper for the cascaded BCD counter.
package bcd_counter_chain_pkg;

    localparam int DIGIT_W = 4;

    // Bit offset of digit k inside a packed multi-digit vector.
    function automatic int digit_lsb(input int k);
        return DIGIT_W * k;
    endfunction

endpackage

// File: rtl/bcd_counter_chain_if.sv
// Control and count bus between an enable source and the counter chain.
interface bcd_counter_chain_if
    import bcd_counter_chain_pkg::*;
#(
    parameter int DIGITS = 3
);
    logic                      Clear;
    logic                      Load;
    logic [DIGIT_W*DIGITS-1:0] LoadVal;
    logic                      CountEn;
    logic                      Up;
    logic [DIGIT_W*DIGITS-1:0] COut;
    logic                      Carry;
    logic                      Ovf;

    modport master (
        output Clear, Load, LoadVal, CountEn, Up,
        input  COut, Carry, Ovf
    );

    modport slave (
        input  Clear, Load, LoadVal, CountEn, Up,
        output COut, Carry, Ovf
    );
endinterface

// File: rtl/bcd_counter_chain_digit_cell.sv
// One digit register: clear/load/count with wrap at DIGIT_MAX in both directions.
module digit_cell
    import bcd_counter_chain_pkg::*;
#(
    parameter int DIGIT_MAX = 9
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic               Clear,
    input  logic               Load,
    input  logic [DIGIT_W-1:0] LoadNib,
    input  logic               En,
    input  logic               Up,
    output logic [DIGIT_W-1:0] Q,
    output logic               AtMax,
    output logic               AtZero
);
    localparam logic [DIGIT_W-1:0] MAXV = DIGIT_W'(DIGIT_MAX);

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            Q <= '0;
        end else if (Clear) begin
            Q <= '0;
        end else if (Load) begin
            // Out-of-range nibbles are clamped so illegal digit states never exist.
            Q <= (LoadNib > MAXV) ? MAXV : LoadNib;
        end else if (En) begin
            if (Up)
                Q <= AtMax ? '0 : Q + 4'd1;
            else
                Q <= AtZero ? MAXV : Q - 4'd1;
        end
    end

    assign AtMax  = (Q == MAXV);
    assign AtZero = (Q == '0);

endmodule

// File: rtl/bcd_counter_chain.sv
// Multi-digit cascaded up/down counter with wrap/saturate, carry pulse and sticky overflow.
module bcd_counter_chain
    import bcd_counter_chain_pkg::*;
#(
    parameter int DIGITS    = 3,
    parameter int DIGIT_MAX = 9,
    parameter int SATURATE  = 0
) (
    input logic                   Clk,
    input logic                   nReset,
    bcd_counter_chain_if.slave    bus
);
    logic [DIGITS:0]           chain;
    logic [DIGITS-1:0]         at_max;
    logic [DIGITS-1:0]         at_zero;
    logic [DIGITS-1:0]         dig_en;
    logic [DIGIT_W*DIGITS-1:0] count;
    logic                      term;
    logic                      hold;
    logic                      carry_r;
    logic                      ovf_r;

    // Ripple-enable: a digit moves only when every lower digit is at its roll point.
    assign chain[0] = bus.CountEn;
    assign term     = chain[DIGITS];
    assign hold     = (SATURATE != 0) && term;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign chain[k+1] = chain[k] & (bus.Up ? at_max[k] : at_zero[k]);
        assign dig_en[k]  = chain[k] & ~hold;

        digit_cell #(
            .DIGIT_MAX (DIGIT_MAX)
        ) u_cell (
            .Clk     (Clk),
            .nReset  (nReset),
            .Clear   (bus.Clear),
            .Load    (bus.Load),
            .LoadNib (bus.LoadVal[digit_lsb(k) +: DIGIT_W]),
            .En      (dig_en[k]),
            .Up      (bus.Up),
            .Q       (count[digit_lsb(k) +: DIGIT_W]),
            .AtMax   (at_max[k]),
            .AtZero  (at_zero[k])
        );
    end

    always_ff @(posedge Clk) begin
        if (!nReset || bus.Clear || bus.Load) begin
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            carry_r <= term;
            if (term)
                ovf_r <= 1'b1;
        end
    end

    assign bus.COut  = count;
    assign bus.Carry = carry_r;
    assign bus.Ovf   = ovf_r;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Scoreboard bench: three counter configurations share stimulus and are checked against an integer model.
module tb_bcd_counter_chain;

    logic clk;
    logic nreset;

    bcd_counter_chain_if #(.DIGITS(3)) ifa ();
    bcd_counter_chain_if #(.DIGITS(3)) ifb ();
    bcd_counter_chain_if #(.DIGITS(2)) ifc ();

    bcd_counter_chain #(.DIGITS(3), .DIGIT_MAX(9),  .SATURATE(0)) dut_wrap (.Clk(clk), .nReset(nreset), .bus(ifa.slave));
    bcd_counter_chain #(.DIGITS(3), .DIGIT_MAX(9),  .SATURATE(1)) dut_sat  (.Clk(clk), .nReset(nreset), .bus(ifb.slave));
    bcd_counter_chain #(.DIGITS(2), .DIGIT_MAX(15), .SATURATE(0)) dut_hex  (.Clk(clk), .nReset(nreset), .bus(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][11:0] cout;
        logic [2:0]       cy;
        logic [2:0]       ov;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: count held as a plain integer per configuration.
    int   md[3] = '{3, 3, 2};
    int   mb[3] = '{10, 10, 16};
    int   ms[3] = '{0, 1, 0};
    int   mv[3];
    logic mc[3];
    logic mo[3];

    function automatic int modulus(input int d, input int b);
        int m = 1;
        for (int k = 0; k < d; k++) m = m * b;
        return m;
    endfunction

    function automatic int load_value(input logic [11:0] lv, input int d, input int b);
        int v = 0;
        int w = 1;
        for (int k = 0; k < d; k++) begin
            int n = int'(lv[4*k +: 4]);
            if (n > b - 1) n = b - 1;
            v = v + n * w;
            w = w * b;
        end
        return v;
    endfunction

    function automatic logic [11:0] to_digits(input int v, input int d, input int b);
        logic [11:0] r = '0;
        int x = v;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(x % b);
            x = x / b;
        end
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [11:0] got, input logic [11:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h at %0t", name, idx, got, want, $time);
        end
    endtask

    task automatic step(input logic r, input logic cl, input logic ld, input logic [11:0] lv,
                        input logic en, input logic up);
        exp_t e;
        @(negedge clk);
        nreset = r;
        ifa.Clear = cl; ifb.Clear = cl; ifc.Clear = cl;
        ifa.Load = ld;  ifb.Load = ld;  ifc.Load = ld;
        ifa.LoadVal = lv; ifb.LoadVal = lv; ifc.LoadVal = lv[7:0];
        ifa.CountEn = en; ifb.CountEn = en; ifc.CountEn = en;
        ifa.Up = up; ifb.Up = up; ifc.Up = up;
        for (int i = 0; i < 3; i++) begin
            int m = modulus(md[i], mb[i]);
            if (!r || cl) begin
                mv[i] = 0; mc[i] = 1'b0; mo[i] = 1'b0;
            end else if (ld) begin
                mv[i] = load_value(lv, md[i], mb[i]); mc[i] = 1'b0; mo[i] = 1'b0;
            end else if (en) begin
                logic t;
                t = up ? (mv[i] == m - 1) : (mv[i] == 0);
                if (t && ms[i] != 0)
                    mv[i] = mv[i];
                else if (up)
                    mv[i] = (mv[i] + 1) % m;
                else
                    mv[i] = (mv[i] + m - 1) % m;
                mc[i] = t;
                if (t) mo[i] = 1'b1;
            end else begin
                mc[i] = 1'b0;
            end
            e.cout[i] = to_digits(mv[i], md[i], mb[i]);
            e.cy[i]   = mc[i];
            e.ov[i]   = mo[i];
        end
        sbq.push_back(e);
    endtask

    // Monitor: each expected entry matches the outputs just after the next active edge.
    always @(posedge clk) begin
        #1;
        while (sbq.size() > 0) begin
            exp_t e;
            logic [2:0][11:0] got_c;
            logic [2:0]       got_cy;
            logic [2:0]       got_ov;
            e = sbq.pop_front();
            got_c[0] = ifa.COut; got_c[1] = ifb.COut; got_c[2] = {4'h0, ifc.COut};
            got_cy = {ifc.Carry, ifb.Carry, ifa.Carry};
            got_ov = {ifc.Ovf, ifb.Ovf, ifa.Ovf};
            for (int i = 0; i < 3; i++) begin
                check("cout",  i, got_c[i], e.cout[i]);
                check("carry", i, {11'b0, got_cy[i]}, {11'b0, e.cy[i]});
                check("ovf",   i, {11'b0, got_ov[i]}, {11'b0, e.ov[i]});
            end
        end
    end

    initial begin
        nreset = 1'b0;
        ifa.Clear = 0; ifb.Clear = 0; ifc.Clear = 0;
        ifa.Load = 0;  ifb.Load = 0;  ifc.Load = 0;
        ifa.LoadVal = '0; ifb.LoadVal = '0; ifc.LoadVal = '0;
        ifa.CountEn = 0; ifb.CountEn = 0; ifc.CountEn = 0;
        ifa.Up = 1; ifb.Up = 1; ifc.Up = 1;

        // Reset dominates load and count enable.
        repeat (2) step(1'b0, 1'b0, 1'b1, 12'h555, 1'b1, 1'b1);
        repeat (1234) step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);

        // Cascaded ripple up and down across two digits.
        step(1'b1, 1'b0, 1'b1, 12'h199, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 12'h200, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);

        // Terminal events in both directions.
        step(1'b1, 1'b0, 1'b1, 12'h999, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);

        // Saturation run from one below terminal.
        step(1'b1, 1'b0, 1'b1, 12'h998, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);

        // Clear beats load; per-nibble clamping on load.
        step(1'b1, 1'b1, 1'b1, 12'h777, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 12'hFAB, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);

        // Full hex cycle of the two-digit instance.
        step(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
        repeat (256) step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
        repeat (300) step(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);

        // Random mix of all controls.
        repeat (2000) begin
            logic r, cl, ld, en, up;
            logic [11:0] lv;
            r  = ($urandom_range(0, 199) != 0);
            cl = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 29) == 0);
            en = ($urandom_range(0, 9) < 8);
            up = ($urandom_range(0, 2) != 0);
            lv = 12'($urandom);
            if ($urandom_range(0, 3) == 0) lv = 12'h999;
            step(r, cl, ld, lv, en, up);
        end

        @(posedge clk);
        #2;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
